// File: rtl/control_unit.sv
// control_unit: hardwired fetch/execute sequencer for the Phase 3 RISC CPU.
// States RESET, T0-T7 and HALT. Every output is decoded from the state
// register and the registered opcode. The only input that reaches an output
// combinationally is CON, and only in T6 of brx.
// Optional feature macro: CU_MEM_WAIT_EN adds a mem_ready handshake. T1, T6
// of ld and T7 of st then hold until mem_ready is sampled high.
module control_unit #(
  parameter int OPW = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
`ifdef CU_MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        memRead,
  output logic        ramEnable,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        R15in,
  output logic        Cout,
  output logic        CONin,
  output logic        InPort_Out,
  output logic        OutPort_In,
  output logic        ADD,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [4:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_BRX, C_JR,
    C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
  } op_class_t;

  // ALU code used for address and branch-offset additions
  localparam logic [4:0] ALU_ADD = 5'd3;

  state_t          state_q, state_d;
  logic [OPW-1:0]  opcode_q, opcode_d;
  op_class_t       op_class;
  logic [2:0]      last_t;
  logic [31:0]     op_w;
  logic            mem_ok;
  logic            exec;
  logic            ir_unused;

  // Only the opcode field of IR is consumed here.
  assign ir_unused = ^IR[31-OPW:0];

`ifdef CU_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  assign op_w = 32'(opcode_q);
  assign exec = (state_q == S_T3) || (state_q == S_T4) || (state_q == S_T5) ||
                (state_q == S_T6) || (state_q == S_T7);

  // Classify the registered opcode and find the final T-step of its sequence
  always_comb begin
    op_class = C_ILL;
    if (op_w == 32'd0)                         op_class = C_LD;
    else if (op_w == 32'd1)                    op_class = C_LDI;
    else if (op_w == 32'd2)                    op_class = C_ST;
    else if (op_w >= 32'd3 && op_w <= 32'd11)  op_class = C_ALU;
    else if (op_w >= 32'd12 && op_w <= 32'd14) op_class = C_IMM;
    else if (op_w == 32'd15 || op_w == 32'd16) op_class = C_MULDIV;
    else if (op_w == 32'd17 || op_w == 32'd18) op_class = C_NEGNOT;
    else if (op_w == 32'd19)                   op_class = C_BRX;
    else if (op_w == 32'd20)                   op_class = C_JR;
    else if (op_w == 32'd21)                   op_class = C_JAL;
    else if (op_w == 32'd22)                   op_class = C_IN;
    else if (op_w == 32'd23)                   op_class = C_OUT;
    else if (op_w == 32'd24)                   op_class = C_MFHI;
    else if (op_w == 32'd25)                   op_class = C_MFLO;
    else if (op_w == 32'd26)                   op_class = C_NOP;
    else if (op_w == 32'd27)                   op_class = C_HALT;

    last_t = 3'd3;
    case (op_class)
      C_LD, C_ST:                 last_t = 3'd7;
      C_LDI, C_ALU, C_IMM:        last_t = 3'd5;
      C_MULDIV, C_BRX:            last_t = 3'd6;
      C_NEGNOT, C_JAL:            last_t = 3'd4;
      default:                    last_t = 3'd3;
    endcase
  end

  // State and opcode registers; clear wins over everything
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_RESET;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-state sequencing, opcode capture on the T2->T3 edge
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (mem_ok) state_d = S_T2;
      S_T2: begin
        state_d  = S_T3;
        opcode_d = IR[31 -: OPW];
      end
      S_T3: begin
        if (op_class == C_HALT)   state_d = S_HALT;
        else if (last_t == 3'd3)  state_d = S_T0;
        else                      state_d = S_T4;
      end
      S_T4:    state_d = (last_t == 3'd4) ? S_T0 : S_T5;
      S_T5:    state_d = (last_t == 3'd5) ? S_T0 : S_T6;
      S_T6: begin
        if (op_class == C_LD && !mem_ok) state_d = S_T6;
        else                              state_d = (last_t == 3'd6) ? S_T0 : S_T7;
      end
      S_T7: begin
        if (op_class == C_ST && !mem_ok) state_d = S_T7;
        else                              state_d = S_T0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // Moore output decode from state and opcode class
  always_comb begin
    PCout = 1'b0; IncPC = 1'b0; PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; memRead = 1'b0; ramEnable = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; HIin = 1'b0; HIout = 1'b0;
    LOin = 1'b0; LOout = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0;
    Rout = 1'b0; BAout = 1'b0; R15in = 1'b0; Cout = 1'b0; CONin = 1'b0;
    InPort_Out = 1'b0; OutPort_In = 1'b0; ADD = 1'b0; alu_op = 5'd0;
    illegal = 1'b0;
    run = (state_q != S_RESET) && (state_q != S_HALT);

    case (state_q)
      S_T0:    begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1:    begin memRead = 1'b1; MDRin = 1'b1; end
      S_T2:    begin MDRout = 1'b1; IRin = 1'b1; end
      default: ;
    endcase

    if (exec) begin
      case (op_class)
        C_LD, C_LDI, C_ST: begin
          case (state_q)
            S_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            S_T4: begin Cout = 1'b1; ADD = 1'b1; alu_op = ALU_ADD; Zin = 1'b1; end
            S_T5: begin
              Zlowout = 1'b1;
              if (op_class == C_LDI) begin Gra = 1'b1; Rin = 1'b1; end
              else                   MARin = 1'b1;
            end
            S_T6: begin
              MDRin = 1'b1;
              if (op_class == C_ST) begin Gra = 1'b1; Rout = 1'b1; end
              else                  memRead = 1'b1;
            end
            S_T7: begin
              if (op_class == C_ST) ramEnable = 1'b1;
              else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            default: ;
          endcase
        end
        C_ALU, C_IMM: begin
          case (state_q)
            S_T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            S_T4: begin
              if (op_class == C_IMM) Cout = 1'b1;
              else begin Grc = 1'b1; Rout = 1'b1; end
              alu_op = 5'(opcode_q);
              Zin    = 1'b1;
            end
            S_T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
        C_MULDIV: begin
          case (state_q)
            S_T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            S_T4: begin Grb = 1'b1; Rout = 1'b1; alu_op = 5'(opcode_q); Zin = 1'b1; end
            S_T5: begin Zlowout = 1'b1; LOin = 1'b1; end
            S_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
            default: ;
          endcase
        end
        C_NEGNOT: begin
          case (state_q)
            S_T3: begin Grb = 1'b1; Rout = 1'b1; alu_op = 5'(opcode_q); Zin = 1'b1; end
            S_T4: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
        C_BRX: begin
          case (state_q)
            S_T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            S_T4: begin PCout = 1'b1; Yin = 1'b1; end
            S_T5: begin Cout = 1'b1; ADD = 1'b1; alu_op = ALU_ADD; Zin = 1'b1; end
            // Branch taken only when the latched condition holds
            S_T6: begin Zlowout = CON; PCin = CON; end
            default: ;
          endcase
        end
        C_JR: if (state_q == S_T3) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        C_JAL: begin
          case (state_q)
            S_T3: begin PCout = 1'b1; R15in = 1'b1; end
            S_T4: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default: ;
          endcase
        end
        C_IN:   if (state_q == S_T3) begin InPort_Out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_OUT:  if (state_q == S_T3) begin Gra = 1'b1; Rout = 1'b1; OutPort_In = 1'b1; end
        C_MFHI: if (state_q == S_T3) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_MFLO: if (state_q == S_T3) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_ILL:  if (state_q == S_T3) illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
